// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one external single-port SRAM between the instruction fetch path
// (read-only) and the memory stage (read/write). Each access is a fixed
// multi-cycle transaction of WAIT_CYCLES SRAM cycles followed by a one-cycle
// completion pulse. While either requester is waiting, freeze stalls the
// pipeline.
//
// Parameters:
//   ADDR_W       requester byte-address width
//   SRAM_ADDR_W  SRAM word-address width
//   WAIT_CYCLES  SRAM access cycles per transaction (>= 1)
//
// Ports:
//   clk, rst              system clock (rising edge), synchronous active-high reset
//   if_req/if_addr        fetch read request and byte address
//   if_rdata/if_ready     fetched word (registered) and completion pulse
//   mem_r_en/mem_w_en     memory-stage read / write request
//   mem_addr/mem_wdata    memory-stage byte address and store data
//   mem_rdata/mem_ready   load data (registered) and completion pulse
//   sram_addr/sram_wdata  SRAM word address and write data
//   sram_we               SRAM write enable, active high
//   sram_rdata            SRAM read data, combinational from sram_addr
//   freeze                pipeline stall
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int SRAM_ADDR_W = 16,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   if_req,
    input  logic [ADDR_W-1:0]      if_addr,
    output logic [31:0]            if_rdata,
    output logic                   if_ready,

    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [ADDR_W-1:0]      mem_addr,
    input  logic [31:0]            mem_wdata,
    output logic [31:0]            mem_rdata,
    output logic                   mem_ready,

    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [31:0]            sram_wdata,
    output logic                   sram_we,
    input  logic [31:0]            sram_rdata,

    output logic                   freeze
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } owner_t;

    state_t           state;
    owner_t           owner;
    owner_t           last_owner;
    logic             is_write;
    logic [CNT_W-1:0] cnt;

    logic mem_pend;
    logic if_pend;
    logic grant_mem;

    assign mem_pend = mem_r_en | mem_w_en;
    assign if_pend  = if_req;

    // MEM wins when it is the only requester, or on contention when IF
    // owned the previous transaction (round-robin).
    assign grant_mem = mem_pend & (~if_pend | (last_owner == OWN_IF));

    assign freeze = (if_req & ~if_ready) | (mem_pend & ~mem_ready);

    // Word addressing drops the byte-offset bits and everything above the
    // SRAM range, so requester addresses wrap modulo the SRAM size.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[ADDR_W-1:SRAM_ADDR_W+2], if_addr[1:0],
                                mem_addr[ADDR_W-1:SRAM_ADDR_W+2], mem_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_MEM;
            last_owner <= OWN_MEM;
            is_write   <= 1'b0;
            cnt        <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we    <= 1'b0;
        end else begin
            // Ready outputs are single-cycle pulses.
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;

            case (state)
                IDLE: begin
                    sram_we <= 1'b0;
                    if (mem_pend | if_pend) begin
                        state <= ACCESS;
                        cnt   <= '0;
                        if (grant_mem) begin
                            owner      <= OWN_MEM;
                            // Simultaneous read and write is treated as a write.
                            is_write   <= mem_w_en;
                            sram_we    <= mem_w_en;
                            sram_addr  <= mem_addr[SRAM_ADDR_W+1:2];
                            sram_wdata <= mem_wdata;
                        end else begin
                            owner      <= OWN_IF;
                            is_write   <= 1'b0;
                            sram_we    <= 1'b0;
                            sram_addr  <= if_addr[SRAM_ADDR_W+1:2];
                        end
                    end
                end

                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        // Last SRAM cycle: capture read data and raise the
                        // owner's ready so it is visible in DONE.
                        state   <= DONE;
                        sram_we <= 1'b0;
                        if (owner == OWN_MEM) begin
                            mem_ready <= 1'b1;
                            if (!is_write) begin
                                mem_rdata <= sram_rdata;
                            end
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= sram_rdata;
                        end
                    end
                end

                DONE: begin
                    sram_we    <= 1'b0;
                    last_owner <= owner;
                    state      <= IDLE;
                end

                default: begin
                    state   <= IDLE;
                    sram_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with WAIT_CYCLES=3. A behavioural SRAM
// (combinational read, clocked write) sits on the SRAM pins. Inputs are
// driven 1 time unit after the rising edge; outputs are sampled on the
// falling edge. "Cycle c" of each scenario is the cycle in which the
// request is first presented.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W      = 32;
    localparam int SRAM_ADDR_W = 16;

    logic                   clk;
    logic                   rst;
    logic                   if_req;
    logic [ADDR_W-1:0]      if_addr;
    logic [31:0]            if_rdata;
    logic                   if_ready;
    logic                   mem_r_en;
    logic                   mem_w_en;
    logic [ADDR_W-1:0]      mem_addr;
    logic [31:0]            mem_wdata;
    logic [31:0]            mem_rdata;
    logic                   mem_ready;
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic [31:0]            sram_wdata;
    logic                   sram_we;
    logic [31:0]            sram_rdata;
    logic                   freeze;

    logic [31:0] sram_mem [0:65535];

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(
        .ADDR_W      (ADDR_W),
        .SRAM_ADDR_W (SRAM_ADDR_W),
        .WAIT_CYCLES (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_we    (sram_we),
        .sram_rdata (sram_rdata),
        .freeze     (freeze)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_rdata = sram_mem[sram_addr];

    always @(posedge clk) begin
        if (sram_we) sram_mem[sram_addr] <= sram_wdata;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycles(input int n);
        rst      = 1'b1;
        if_req   = 1'b0;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        for (int i = 0; i < n; i++) next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        sram_mem[16'h0004] = 32'hE3A00005;
        sram_mem[16'h0005] = 32'hA5A50001;
        sram_mem[16'h0006] = 32'h0BADC0DE;
        sram_mem[16'h0101] = 32'h12345678;

        rst       = 1'b1;
        if_req    = 1'b1;
        if_addr   = '0;
        mem_r_en  = 1'b0;
        mem_w_en  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        // ---- Reset held two cycles with a fetch pending ----
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            @(negedge clk);
            check("rst_if_ready",  32'(if_ready),  0);
            check("rst_mem_ready", 32'(mem_ready), 0);
            check("rst_sram_we",   32'(sram_we),   0);
            check("rst_freeze",    32'(freeze),    1);
        end
        check("rst_if_rdata",  if_rdata,          0);
        check("rst_mem_rdata", mem_rdata,         0);
        check("rst_sram_addr", 32'(sram_addr),    0);
        check("rst_sram_wdata", sram_wdata,       0);
        next_cycle();

        // ---- Fetch alone: word 4 ----
        rst     = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        for (int c = 0; c <= 5; c++) begin
            if (c == 5) if_req = 1'b0;
            @(negedge clk);
            check("fetch_ready",  32'(if_ready), 32'(c == 4));
            check("fetch_freeze", 32'(freeze),   32'(c <= 3));
            check("fetch_we",     32'(sram_we),  0);
            if (c >= 1 && c <= 3) check("fetch_addr", 32'(sram_addr), 32'h4);
            if (c == 4) check("fetch_rdata", if_rdata, 32'hE3A00005);
            next_cycle();
        end

        // ---- Store to 0x400 ----
        mem_w_en  = 1'b1;
        mem_addr  = 32'h0000_0400;
        mem_wdata = 32'hDEADBEEF;
        for (int c = 0; c <= 5; c++) begin
            if (c == 5) mem_w_en = 1'b0;
            @(negedge clk);
            check("store_ready",  32'(mem_ready), 32'(c == 4));
            check("store_we",     32'(sram_we),   32'(c >= 1 && c <= 3));
            check("store_freeze", 32'(freeze),    32'(c <= 3));
            check("store_if_rdy", 32'(if_ready),  0);
            if (c >= 1 && c <= 3) begin
                check("store_addr",  32'(sram_addr), 32'h100);
                check("store_wdata", sram_wdata,     32'hDEADBEEF);
            end
            if (c == 4) check("store_mem_rdata", mem_rdata, 0);
            if (c == 5) check("store_sram_word", sram_mem[16'h0100], 32'hDEADBEEF);
            next_cycle();
        end

        // ---- Contention straight after reset: IF first ----
        reset_cycles(2);
        if_req   = 1'b1;
        if_addr  = 32'h0000_0014;
        mem_r_en = 1'b1;
        mem_addr = 32'h0000_0404;
        for (int c = 0; c <= 10; c++) begin
            if (c == 5)  if_req   = 1'b0;
            if (c == 10) mem_r_en = 1'b0;
            @(negedge clk);
            check("cont_if_ready",  32'(if_ready),  32'(c == 4));
            check("cont_mem_ready", 32'(mem_ready), 32'(c == 9));
            check("cont_freeze",    32'(freeze),    32'(c <= 8));
            if (c >= 1 && c <= 3) check("cont_addr_if",  32'(sram_addr), 32'h5);
            if (c >= 6 && c <= 8) check("cont_addr_mem", 32'(sram_addr), 32'h101);
            if (c == 4) begin
                check("cont_if_rdata",  if_rdata,  32'hA5A50001);
                check("cont_mem_rdata0", mem_rdata, 0);
            end
            if (c == 9) begin
                check("cont_mem_rdata", mem_rdata, 32'h12345678);
                check("cont_if_kept",   if_rdata,  32'hA5A50001);
            end
            next_cycle();
        end

        // ---- Fetch withdrawn in cycle 2 ----
        if_req  = 1'b1;
        if_addr = 32'h0000_0018;
        for (int c = 0; c <= 9; c++) begin
            if (c == 2) if_req = 1'b0;
            @(negedge clk);
            check("wd_ready",     32'(if_ready),  32'(c == 4));
            check("wd_mem_ready", 32'(mem_ready), 0);
            check("wd_freeze",    32'(freeze),    32'(c <= 1));
            check("wd_we",        32'(sram_we),   0);
            if (c >= 1 && c <= 3) check("wd_addr", 32'(sram_addr), 32'h6);
            if (c == 4) check("wd_rdata", if_rdata, 32'h0BADC0DE);
            next_cycle();
        end

        // ---- Contention after an IF transaction: MEM first, R+W = write ----
        if_req    = 1'b1;
        if_addr   = 32'h0000_0010;
        mem_r_en  = 1'b1;
        mem_w_en  = 1'b1;
        mem_addr  = 32'h0000_0408;
        mem_wdata = 32'hCAFEF00D;
        for (int c = 0; c <= 10; c++) begin
            if (c == 5) begin
                mem_r_en = 1'b0;
                mem_w_en = 1'b0;
            end
            if (c == 10) if_req = 1'b0;
            @(negedge clk);
            check("rr_mem_ready", 32'(mem_ready), 32'(c == 4));
            check("rr_if_ready",  32'(if_ready),  32'(c == 9));
            check("rr_we",        32'(sram_we),   32'(c >= 1 && c <= 3));
            if (c >= 1 && c <= 3) check("rr_addr_mem", 32'(sram_addr), 32'h102);
            if (c >= 6 && c <= 8) check("rr_addr_if",  32'(sram_addr), 32'h4);
            if (c == 4) check("rr_mem_rdata", mem_rdata, 32'h12345678);
            if (c == 5) check("rr_sram_word", sram_mem[16'h0102], 32'hCAFEF00D);
            if (c == 9) check("rr_if_rdata", if_rdata, 32'hE3A00005);
            next_cycle();
        end

        // ---- Reset in cycle 2 of a store, then a fetch from IDLE ----
        mem_w_en  = 1'b1;
        mem_addr  = 32'h0000_040C;
        mem_wdata = 32'h11112222;
        for (int c = 0; c <= 8; c++) begin
            if (c == 2) rst = 1'b1;
            if (c == 3) begin
                rst      = 1'b0;
                mem_w_en = 1'b0;
                if_req   = 1'b1;
                if_addr  = 32'h0000_0010;
            end
            if (c == 8) if_req = 1'b0;
            @(negedge clk);
            check("rw_we",        32'(sram_we),   32'(c >= 1 && c <= 2));
            check("rw_mem_ready", 32'(mem_ready), 0);
            check("rw_if_ready",  32'(if_ready),  32'(c == 7));
            if (c == 3) begin
                check("rw_mem_rdata", mem_rdata,      0);
                check("rw_sram_addr", 32'(sram_addr), 0);
            end
            if (c >= 4 && c <= 6) check("rw_fetch_addr", 32'(sram_addr), 32'h4);
            if (c == 7) check("rw_if_rdata", if_rdata, 32'hE3A00005);
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
